// File: rtl/sdram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_arbiter_if
//   Bundles the four upstream client ports and the single downstream SDRAM
//   controller request/response side of sdram_arbiter.
//
//   Upstream (per port N, slice/bit N):
//     i_request, i_rw (1 = write), i_address, i_wdata, i_wmask -> arbiter
//     o_rdata, o_ready                                         <- arbiter
//   Downstream:
//     o_sdram_request, o_sdram_rw, o_sdram_address,
//     o_sdram_wdata, o_sdram_wmask                             <- arbiter
//     i_sdram_rdata, i_sdram_ready                             -> arbiter
//
//   Modports:
//     slave  - the arbiter's view
//     master - the client / controller-model view
// ---------------------------------------------------------------------------
interface sdram_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [3:0]                  i_request;
    logic [3:0]                  i_rw;
    logic [3:0][31:0]            i_address;
    logic [3:0][DATA_WIDTH-1:0]  i_wdata;
    logic [3:0][3:0]             i_wmask;
    logic [3:0][DATA_WIDTH-1:0]  o_rdata;
    logic [3:0]                  o_ready;

    logic                        o_sdram_request;
    logic                        o_sdram_rw;
    logic [31:0]                 o_sdram_address;
    logic [DATA_WIDTH-1:0]       o_sdram_wdata;
    logic [3:0]                  o_sdram_wmask;
    logic [DATA_WIDTH-1:0]       i_sdram_rdata;
    logic                        i_sdram_ready;

    modport slave (
        input  i_request, i_rw, i_address, i_wdata, i_wmask,
        output o_rdata, o_ready,
        output o_sdram_request, o_sdram_rw, o_sdram_address,
               o_sdram_wdata, o_sdram_wmask,
        input  i_sdram_rdata, i_sdram_ready
    );

    modport master (
        output i_request, i_rw, i_address, i_wdata, i_wmask,
        input  o_rdata, o_ready,
        input  o_sdram_request, o_sdram_rw, o_sdram_address,
               o_sdram_wdata, o_sdram_wmask,
        output i_sdram_rdata, i_sdram_ready
    );
endinterface

// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
//   Four-port arbiter in front of a single SDRAM controller. Both sides use a
//   level handshake: request held until ready, ready held until request
//   drops. One transaction is in flight at a time (IDLE -> ISSUE -> RELEASE).
//
//   Ports:
//     i_clock  - single clock
//     i_reset  - asynchronous, active-high reset
//     bus      - sdram_arbiter_if.slave: upstream ports and SDRAM side
//
//   Configuration:
//     SDRAM_ARBITER_ROUND_ROBIN_EN defined   - round-robin search starting
//                                              after the last grant
//     SDRAM_ARBITER_ROUND_ROBIN_EN undefined - fixed priority, port 0 highest
// ---------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic           i_clock,
    input  logic           i_reset,
    sdram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE
    } state_t;

    state_t                      state;
    logic [1:0]                  grant;
    logic [1:0]                  next_grant;
    logic [1:0]                  search_start;
    logic [1:0]                  search_idx;
    logic                        search_found;

    logic                        req_q;
    logic                        rw_q;
    logic [31:0]                 addr_q;
    logic [DATA_WIDTH-1:0]       wdata_q;
    logic [3:0]                  wmask_q;
    logic [3:0]                  ready_q;
    logic [3:0][DATA_WIDTH-1:0]  rdata_q;

`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
    logic [1:0]                  last_grant;

    assign search_start = last_grant + 2'd1;
`else
    assign search_start = 2'd0;
`endif

    // First requesting port at or after search_start (wrapping mod 4).
    always_comb begin
        next_grant   = search_start;
        search_idx   = search_start;
        search_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            search_idx = search_start + 2'(i);
            if (!search_found && bus.i_request[search_idx]) begin
                next_grant   = search_idx;
                search_found = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            grant   <= '0;
            req_q   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            ready_q <= '0;
            rdata_q <= '0;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
            last_grant <= 2'd3;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Holding off while the controller still shows ready lets
                    // a controller stranded mid-handshake by reset drain first.
                    if (|bus.i_request && !bus.i_sdram_ready) begin
                        grant   <= next_grant;
                        rw_q    <= bus.i_rw[next_grant];
                        addr_q  <= bus.i_address[next_grant];
                        wdata_q <= bus.i_wdata[next_grant];
                        wmask_q <= bus.i_wmask[next_grant];
                        req_q   <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.i_sdram_ready) begin
                        req_q <= 1'b0;
                        // A port that gave up during ISSUE gets neither data
                        // nor ready; the downstream access still completes.
                        if (bus.i_request[grant]) begin
                            ready_q[grant] <= 1'b1;
                            if (!rw_q) begin
                                rdata_q[grant] <= bus.i_sdram_rdata;
                            end
                        end
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!bus.i_request[grant]) begin
                        ready_q[grant] <= 1'b0;
                    end
                    if (!bus.i_sdram_ready && !bus.i_request[grant] && !ready_q[grant]) begin
                        state <= IDLE;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
                        last_grant <= grant;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_sdram_request = req_q;
    assign bus.o_sdram_rw      = rw_q;
    assign bus.o_sdram_address = addr_q;
    assign bus.o_sdram_wdata   = wdata_q;
    assign bus.o_sdram_wmask   = wmask_q;
    assign bus.o_ready         = ready_q;
    assign bus.o_rdata         = rdata_q;

endmodule
